// File: rtl/smp_io_regs.sv
// smp_io_regs -- SMP I/O register file at $00F0-$00FF.
// Sits downstream of the SPC700 core bus. It decodes core accesses and holds
// CONTROL, the DSP address latch, four host ports in each direction, two
// scratch registers and three timers.
// Ports:
//   CLK, RST_N         clock, synchronous active-low reset
//   CE                 one pulse per core bus cycle; qualifies all core side-effects
//   CPU_A/DO/WE_N      core address, write data, write strobe (active-low)
//   IO_SEL, IO_DI      decode hit and read data back to the core (combinational)
//   DSP_A/DO/WE/DI     DSP register port ($F2 latch, $F3 data)
//   HP_A/DI/WE/DO      S-CPU side of the four host ports
//   IPL_EN             CONTROL[7], maps the IPL ROM at $FFC0
module smp_io_regs #(
  parameter int T01_DIV = 128,
  parameter int T2_DIV  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_WE_N,
  output logic        IO_SEL,
  output logic [7:0]  IO_DI,
  output logic [7:0]  DSP_A,
  output logic [7:0]  DSP_DO,
  output logic        DSP_WE,
  input  logic [7:0]  DSP_DI,
  input  logic [1:0]  HP_A,
  input  logic [7:0]  HP_DI,
  input  logic        HP_WE,
  output logic [7:0]  HP_DO,
  output logic        IPL_EN
);

  localparam int P01W = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
  localparam int P2W  = (T2_DIV > 1) ? $clog2(T2_DIV) : 1;
  localparam logic [P01W-1:0] LAST01 = P01W'(T01_DIV - 1);
  localparam logic [P2W-1:0]  LAST2  = P2W'(T2_DIV - 1);

  logic            r_ipl;
  logic [2:0]      r_ten;
  logic [7:0]      r_dsp_a;
  logic [7:0]      r_in   [4];
  logic [7:0]      r_out  [4];
  logic [7:0]      r_scr  [2];
  logic [7:0]      r_tgt  [3];
  logic [7:0]      r_stage[3];
  logic [3:0]      r_cnt  [3];
  logic [P01W-1:0] r_pre01;
  logic [P2W-1:0]  r_pre2;

  logic       w_wr;
  logic       w_rd;
  logic [3:0] w_lo;
  logic       w_t01;
  logic       w_t2;
  logic [2:0] w_tick;
  logic       w_ctrl_wr;
  logic [7:0] w_stage_nx[3];
  logic [3:0] w_cnt_nx  [3];

  assign IO_SEL    = (CPU_A[15:4] == 12'h00F);
  assign w_lo      = CPU_A[3:0];
  assign w_wr      = CE & IO_SEL & ~CPU_WE_N;
  assign w_rd      = CE & IO_SEL & CPU_WE_N;
  assign w_ctrl_wr = w_wr & (w_lo == 4'h1);

  assign w_t01  = CE & (r_pre01 == LAST01);
  assign w_t2   = CE & (r_pre2 == LAST2);
  assign w_tick = {w_t2, w_t01, w_t01};

  assign DSP_A  = r_dsp_a;
  assign DSP_DO = CPU_DO;
  // Gated by RST_N so a write strobe coinciding with reset never reaches the DSP.
  assign DSP_WE = RST_N & w_wr & (w_lo == 4'h3);
  assign HP_DO  = r_out[HP_A];
  assign IPL_EN = r_ipl;

  always_comb begin
    IO_DI = '0;
    if (IO_SEL) begin
      case (w_lo)
        4'h2:                   IO_DI = r_dsp_a;
        4'h3:                   IO_DI = DSP_DI;
        4'h4, 4'h5, 4'h6, 4'h7: IO_DI = r_in[w_lo[1:0]];
        4'h8:                   IO_DI = r_scr[0];
        4'h9:                   IO_DI = r_scr[1];
        4'hD:                   IO_DI = {4'b0, r_cnt[0]};
        4'hE:                   IO_DI = {4'b0, r_cnt[1]};
        4'hF:                   IO_DI = {4'b0, r_cnt[2]};
        default:                IO_DI = '0;
      endcase
    end
  end

  // Timer next-state. Priority, lowest to highest: tick, read-clear of the
  // counter (keeps a coincident increment as 1), CONTROL enable 0->1 clear.
  always_comb begin
    logic [8:0] sum;
    logic [8:0] tgt;
    logic       hit;
    for (int unsigned n = 0; n < 3; n++) begin
      w_stage_nx[n] = r_stage[n];
      w_cnt_nx[n]   = r_cnt[n];
      sum = {1'b0, r_stage[n]} + 9'd1;
      tgt = (r_tgt[n] == 8'd0) ? 9'd256 : {1'b0, r_tgt[n]};
      hit = 1'b0;
      if (r_ten[n] && w_tick[n]) begin
        if (sum == tgt) begin
          w_stage_nx[n] = '0;
          hit = 1'b1;
        end else begin
          w_stage_nx[n] = sum[7:0];
        end
      end
      if (w_rd && (w_lo == 4'hD + 4'(n)))
        w_cnt_nx[n] = {3'b0, hit};
      else if (hit)
        w_cnt_nx[n] = r_cnt[n] + 4'd1;
      if (w_ctrl_wr && CPU_DO[n] && !r_ten[n]) begin
        w_stage_nx[n] = '0;
        w_cnt_nx[n]   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ipl   <= 1'b1;
      r_ten   <= '0;
      r_dsp_a <= '0;
      r_pre01 <= '0;
      r_pre2  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_in[i]  <= '0;
        r_out[i] <= '0;
      end
      for (int unsigned i = 0; i < 2; i++) r_scr[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_tgt[i]   <= '0;
        r_stage[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      if (CE) begin
        r_pre01 <= (r_pre01 == LAST01) ? '0 : r_pre01 + 1'b1;
        r_pre2  <= (r_pre2 == LAST2) ? '0 : r_pre2 + 1'b1;
      end
      if (w_wr) begin
        case (w_lo)
          4'h1: begin
            r_ipl <= CPU_DO[7];
            r_ten <= CPU_DO[2:0];
          end
          4'h2:                   r_dsp_a <= CPU_DO;
          4'h4, 4'h5, 4'h6, 4'h7: r_out[w_lo[1:0]] <= CPU_DO;
          4'h8:                   r_scr[0] <= CPU_DO;
          4'h9:                   r_scr[1] <= CPU_DO;
          4'hA:                   r_tgt[0] <= CPU_DO;
          4'hB:                   r_tgt[1] <= CPU_DO;
          4'hC:                   r_tgt[2] <= CPU_DO;
          default: ;
        endcase
      end
      for (int unsigned i = 0; i < 3; i++) begin
        r_stage[i] <= w_stage_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
      // Host write is placed last so it overrides a coincident CONTROL clear.
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_ctrl_wr && ((i < 2) ? CPU_DO[4] : CPU_DO[5]))
          r_in[i] <= '0;
        if (HP_WE && (HP_A == 2'(i)))
          r_in[i] <= HP_DI;
      end
    end
  end

endmodule

// File: tb/tb_smp_io_regs.sv
// tb_smp_io_regs -- directed-vector bench for smp_io_regs.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ce_total counts CE edges taken out of reset, which fixes the prescaler phase.
module tb_smp_io_regs;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic [15:0] CPU_A;
  logic [7:0]  CPU_DO;
  logic        CPU_WE_N;
  logic        IO_SEL;
  logic [7:0]  IO_DI;
  logic [7:0]  DSP_A;
  logic [7:0]  DSP_DO;
  logic        DSP_WE;
  logic [7:0]  DSP_DI;
  logic [1:0]  HP_A;
  logic [7:0]  HP_DI;
  logic        HP_WE;
  logic [7:0]  HP_DO;
  logic        IPL_EN;

  int n_vec = 0;
  int n_err = 0;
  int ce_total = 0;

  smp_io_regs #(.T01_DIV(128), .T2_DIV(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CPU_A(CPU_A), .CPU_DO(CPU_DO),
    .CPU_WE_N(CPU_WE_N), .IO_SEL(IO_SEL), .IO_DI(IO_DI), .DSP_A(DSP_A),
    .DSP_DO(DSP_DO), .DSP_WE(DSP_WE), .DSP_DI(DSP_DI), .HP_A(HP_A),
    .HP_DI(HP_DI), .HP_WE(HP_WE), .HP_DO(HP_DO), .IPL_EN(IPL_EN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [15:0] a, input logic [7:0] d, input logic we_n, input logic ce);
    CPU_A    = a;
    CPU_DO   = d;
    CPU_WE_N = we_n;
    CE       = ce;
  endtask

  task automatic step();
    @(posedge CLK);
    if (CE && RST_N) ce_total++;
    @(negedge CLK);
  endtask

  task automatic bus_idle();
    drv(16'h0000, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic ce = 1'b1);
    drv(a, d, 1'b0, ce);
    step();
    bus_idle();
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    drv(a, 8'h00, 1'b1, 1'b1);
    #1 chk(tag, IO_DI, exp);
    step();
    bus_idle();
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) step();
  endtask

  initial begin
    RST_N = 1'b0;
    DSP_DI = 8'hA5;
    HP_A = 2'd0;
    HP_DI = 8'h00;
    HP_WE = 1'b0;
    bus_idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    ce_total = 0;

    // Reset state
    #1;
    chk("rst_ipl_en", {7'b0, IPL_EN}, 8'h01);
    chk("rst_dsp_we", {7'b0, DSP_WE}, 8'h00);
    chk("rst_dsp_a", DSP_A, 8'h00);
    rd("rst_f1", 16'h00F1, 8'h00);
    rd("rst_fd", 16'h00FD, 8'h00);
    rd("rst_f4", 16'h00F4, 8'h00);

    // Scratch, write-only regs, decode miss, CE qualification
    wr(16'h00F8, 8'hAA);
    wr(16'h00F9, 8'h55);
    rd("scr0", 16'h00F8, 8'hAA);
    rd("scr1", 16'h00F9, 8'h55);
    wr(16'h00F8, 8'h11, 1'b0);
    rd("scr0_no_ce", 16'h00F8, 8'hAA);
    wr(16'h00F0, 8'h3C);
    rd("test_f0", 16'h00F0, 8'h00);
    wr(16'h00FB, 8'h77);
    rd("tgt_fb", 16'h00FB, 8'h00);
    drv(16'h00E3, 8'h00, 1'b1, 1'b1);
    #1;
    chk("miss_sel", {7'b0, IO_SEL}, 8'h00);
    chk("miss_di", IO_DI, 8'h00);
    bus_idle();

    // DSP port
    wr(16'h00F2, 8'h4C);
    chk("dsp_a", DSP_A, 8'h4C);
    rd("dsp_a_rd", 16'h00F2, 8'h4C);
    drv(16'h00F3, 8'h9F, 1'b0, 1'b1);
    #1;
    chk("dsp_we_on", {7'b0, DSP_WE}, 8'h01);
    chk("dsp_do", DSP_DO, 8'h9F);
    step();
    bus_idle();
    #1 chk("dsp_we_off", {7'b0, DSP_WE}, 8'h00);
    rd("dsp_di", 16'h00F3, 8'hA5);

    // Host ports
    HP_A = 2'd1; HP_DI = 8'h5A; HP_WE = 1'b1;
    step();
    HP_WE = 1'b0;
    rd("hp_in1", 16'h00F5, 8'h5A);
    HP_A = 2'd2; HP_DI = 8'hC3; HP_WE = 1'b1;
    step();
    HP_WE = 1'b0;
    wr(16'h00F1, 8'h10);
    rd("hp_clr1", 16'h00F5, 8'h00);
    rd("hp_keep2", 16'h00F6, 8'hC3);
    chk("ipl_off", {7'b0, IPL_EN}, 8'h00);
    HP_A = 2'd1; HP_DI = 8'h77; HP_WE = 1'b1;
    wr(16'h00F1, 8'h10);
    HP_WE = 1'b0;
    rd("hp_we_wins", 16'h00F5, 8'h77);
    wr(16'h00F5, 8'h33);
    HP_A = 2'd1;
    #1 chk("hp_do1", HP_DO, 8'h33);
    HP_A = 2'd0;
    #1 chk("hp_do0", HP_DO, 8'h00);

    // Timer 0 target 2: any 256-CE window holds exactly two T01 ticks
    wr(16'h00FA, 8'h02);
    wr(16'h00FB, 8'h04);
    wr(16'h00F1, 8'h83);
    chk("ipl_on", {7'b0, IPL_EN}, 8'h01);
    idle(256);
    rd("t0_cnt", 16'h00FD, 8'h01);
    rd("t0_reread", 16'h00FD, 8'h00);
    rd("t1_below_tgt", 16'h00FE, 8'h00);

    // Read-clear coinciding with an increment. Align so the next CE is a
    // multiple of 128; ticks then land on CE indices 127 mod 128.
    idle((128 - (ce_total % 128)) % 128);
    wr(16'h00F1, 8'h00);
    wr(16'h00FA, 8'h01);
    wr(16'h00F1, 8'h01);
    // 3 CEs used; ticks at +127,+255,+383 give cnt=3; the read lands on +511.
    idle(508);
    rd("coinc_rd", 16'h00FD, 8'h03);
    rd("coinc_after", 16'h00FD, 8'h01);

    // Timer 2 with target 0 (=256): one count per 4096 CE, 4 bits wrap
    wr(16'h00FC, 8'h00);
    wr(16'h00F1, 8'h04);
    idle(4096);
    rd("t2_4096", 16'h00FF, 8'h01);
    idle(65536);
    rd("t2_wrap", 16'h00FF, 8'h00);

    // Reset coinciding with a DSP write
    drv(16'h00F3, 8'h9F, 1'b0, 1'b1);
    RST_N = 1'b0;
    #1 chk("rst_dsp_we_mid", {7'b0, DSP_WE}, 8'h00);
    step();
    RST_N = 1'b1;
    bus_idle();
    #1;
    chk("rst2_ipl", {7'b0, IPL_EN}, 8'h01);
    chk("rst2_dsp_a", DSP_A, 8'h00);
    rd("rst2_ff", 16'h00FF, 8'h00);
    rd("rst2_f6", 16'h00F6, 8'h00);
    rd("rst2_f8", 16'h00F8, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
